// File: rtl/fifo_pkg.sv
// Shared defaults and operation encoding for the RAM-backed FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // What the FIFO actually does on a given edge after flag qualification.
  typedef enum logic [1:0] {
    FIFO_IDLE_OP,
    FIFO_PUSH,
    FIFO_POP,
    FIFO_BOTH
  } fifo_op_t;

endpackage

// File: rtl/fifo_dp_ram.sv
// Dual-port register file: synchronous write port, asynchronous read port.
// Contents are never cleared; the FIFO pointers decide what is valid.
module fifo_dp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Store the word on the write port when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  // Show-ahead read: the addressed word is visible without a clock.
  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_ram_buffer.sv
// Synchronous show-ahead FIFO: pointers, occupancy count, registered flags
// and one-cycle error pulses around a dual-port register file.
module fifo_ram_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty_reg;
  logic                  full_reg;
  logic                  almost_full_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  push_ok;
  logic                  pop_ok;
  fifo_op_t              op;

  // Qualify requests against the flags and pick the count update.
  // A push while full is allowed only when a pop frees the slot on the same edge;
  // a pop while empty is simply dropped (silently if paired with a push).
  always_comb begin
    push_ok    = wr && (!full_reg || rd);
    pop_ok     = rd && !empty_reg;
    op         = FIFO_IDLE_OP;
    count_next = count_reg;
    if (push_ok && pop_ok) begin
      op = FIFO_BOTH;
    end else if (push_ok) begin
      op = FIFO_PUSH;
    end else if (pop_ok) begin
      op = FIFO_POP;
    end
    case (op)
      FIFO_PUSH: count_next = count_reg + 1'b1;
      FIFO_POP:  count_next = count_reg - 1'b1;
      default:   count_next = count_reg;
    endcase
  end

  // Pointer, count, flag and error-pulse registers; reset overrides any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      empty_reg       <= 1'b1;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg       <= count_next;
      empty_reg       <= (count_next == '0);
      full_reg        <= (count_next == FULL_CNT);
      almost_full_reg <= (count_next >= AF_CNT);
      overflow_reg    <= wr && !rd && full_reg;
      underflow_reg   <= rd && !wr && empty_reg;
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok && !reset),
    .w_addr(wr_ptr_reg),
    .w_data(w_data),
    .r_addr(rd_ptr_reg),
    .r_data(r_data)
  );

  assign count       = count_reg;
  assign empty       = empty_reg;
  assign full        = full_reg;
  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_fifo_ram_buffer.sv
// Directed bench for fifo_ram_buffer with a 4-deep, 8-bit configuration.
module tb_fifo_ram_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_ram_buffer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .AF_LEVEL  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .rd         (rd),
    .w_data     (w_data),
    .r_data     (r_data),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock with the given requests; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr = w;
    rd = r;
    w_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  logic [7:0] exp_q [4];

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    exp_q[0] = 8'hA1; exp_q[1] = 8'hB2; exp_q[2] = 8'hC3; exp_q[3] = 8'hD4;

    // 1: reset state
    cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_af", almost_full, 0);

    // 2: fill to almost-full, then full
    cyc(1'b1, 1'b0, 8'hA1);
    check("first_empty", empty, 0);
    check("first_rdata", r_data, 8'hA1);
    check("first_af", almost_full, 0);
    cyc(1'b1, 1'b0, 8'hB2);
    cyc(1'b1, 1'b0, 8'hC3);
    check("fill3_count", count, 3);
    check("fill3_af", almost_full, 1);
    check("fill3_rdata", r_data, 8'hA1);
    check("fill3_full", full, 0);
    cyc(1'b1, 1'b0, 8'hD4);
    check("fill4_full", full, 1);
    check("fill4_count", count, 4);

    // 3: overflow pulse, then drain in order
    cyc(1'b1, 1'b0, 8'hEE);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_rdata", r_data, 8'hA1);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_clear", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_rdata%0d", i), r_data, exp_q[i]);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    check("drain_af", almost_full, 0);

    // 4: underflow pulse; paired write+read on empty writes only
    cyc(1'b0, 1'b1, 8'h00);
    check("unf_pulse", underflow, 1);
    check("unf_count", count, 0);
    cyc(1'b0, 1'b0, 8'h00);
    check("unf_clear", underflow, 0);
    cyc(1'b1, 1'b1, 8'h55);
    check("wr_rd_empty_count", count, 1);
    check("wr_rd_empty_rdata", r_data, 8'h55);
    check("wr_rd_empty_unf", underflow, 0);

    // 5: simultaneous write+read while full, pointers wrap
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    check("refill_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 8'h77);
      check($sformatf("both_full_count%0d", i), count, 4);
      check($sformatf("both_full_flag%0d", i), full, 1);
      check($sformatf("both_full_ovf%0d", i), overflow, 0);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop77_rdata%0d", i), r_data, 8'h77);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("pop77_empty", empty, 1);

    // 6: reset mid-operation overrides a write
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    check("pre_rst_count", count, 2);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 8'hFF);
    reset = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ovf", overflow, 0);
    cyc(1'b1, 1'b0, 8'h9A);
    check("post_rst_rdata", r_data, 8'h9A);
    check("post_rst_count", count, 1);
    // mid-level write+read keeps the count and advances the head
    cyc(1'b1, 1'b1, 8'hBC);
    check("mid_both_count", count, 1);
    check("mid_both_rdata", r_data, 8'hBC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
